synfull_inj_queue: RTL and testbench
====================================

SYNFULL_INJ_QUEUE -- requirements
Module: synfull_inj_queue

Interface
REQ-001 Parameter DEPTH, 8, number of queued requests per endpoint; SHALL be a power of two, at least 2.
REQ-002 Parameter DST_W, 8, width of the source and destination endpoint index.
REQ-003 Parameter ID_W, 32, width of the packet id.
REQ-004 Parameter SIZE_W, 16, width of the packet size field (flits).
REQ-005 Port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_i, input, 1, asynchronous active-low reset.
REQ-007 Port flush_i, input, 1, synchronous discard of all queued entries.
REQ-008 Ports req_valid_i (1) plus req_src_i (DST_W), req_dest_i (DST_W), req_id_i (ID_W) and req_size_i (SIZE_W), inputs, carry the trace request from the DPI stage.
REQ-009 Port req_ready_o, output, 1, queue not full.
REQ-010 Ports inj_valid_o (1) plus inj_src_o, inj_dest_o, inj_id_o and inj_size_o (same widths as REQ-008), outputs, carry the request to the ProNoC injector.
REQ-011 Port inj_ready_i, input, 1, injector accepts the head request.
REQ-012 Port count_o, output, log2(DEPTH)+1, current occupancy.
REQ-013 Port drop_o, output, 1, one-cycle pulse when a request is discarded.
REQ-014 Ports drop_cnt_o (32) and max_occ_o (log2(DEPTH)+1), outputs, statistics.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries using read/write pointers of log2(DEPTH)+1 bits; the extra MSB disambiguates full from empty.
- Full: pointer indices equal and MSBs differ.
- Empty: pointers fully equal.
REQ-016 A push SHALL occur when req_valid_i=1 and (not full, or a pop occurs in the same cycle); the entry is written at the write pointer, which then increments.
REQ-017 When req_valid_i=1, the queue is full and no pop occurs, the request SHALL be discarded and drop_o SHALL pulse high for exactly that cycle.
REQ-018 req_ready_o SHALL equal not-full, registered-state derived; it SHALL NOT depend combinationally on req_valid_i.
REQ-019 Output SHALL be first-word-fall-through: inj_valid_o = not empty; inj_* fields = the head entry.
REQ-020 A pop SHALL occur when inj_valid_o=1 and inj_ready_i=1; the read pointer then increments.
REQ-021 Latency: a request pushed into an empty queue SHALL appear on inj_valid_o exactly 1 cycle later; there is no same-cycle bypass.
REQ-022 Head fields SHALL remain stable while inj_valid_o=1 and inj_ready_i=0.
REQ-023 Simultaneous push and pop SHALL leave count_o unchanged, including at full and at count=1.
REQ-024 Pointers SHALL wrap modulo 2*DEPTH with no gap or duplicate across the wrap.
REQ-025 count_o SHALL equal write pointer minus read pointer (modulo 2*DEPTH) and SHALL update the cycle after each push or pop.
REQ-026 flush_i=1 SHALL set both pointers to 0 on that edge; any same-cycle push or pop SHALL be ignored, and drop_o SHALL stay 0 in that cycle.

Reset
REQ-027 While rst_i=0, the following SHALL be forced immediately, independent of clk_i:
- pointers = 0
- inj_valid_o = 0, req_ready_o = 1 (reset-state derived)
- count_o = 0, drop_o = 0, drop_cnt_o = 0, max_occ_o = 0
Storage contents are don't-care.
REQ-028 An assertion of rst_i in the middle of traffic SHALL discard all queued entries; the first push after release SHALL be accepted in the first clock edge where rst_i=1.

Configuration
REQ-029 Macro SYNFULL_INJQ_STATS_EN, when defined, SHALL enable the statistics:
- drop_cnt_o increments on every drop_o pulse and saturates at 2^32-1.
- max_occ_o holds the highest count_o value seen since reset; flush_i does not clear it.
REQ-030 Without SYNFULL_INJQ_STATS_EN, drop_cnt_o and max_occ_o SHALL be tied to 0 and no statistics registers SHALL be present; all other behaviour is identical.

Verification
REQ-031 DEPTH=8: push id 1..8 with inj_ready_i=0 -> req_ready_o=0 after the 8th push; a 9th push (id 9) -> drop_o pulses, drop_cnt_o=1 (STATS_EN), count_o=8.
REQ-032 Queue full, then inj_ready_i=1 and push id 10 in the same cycle -> id 1 popped, id 10 accepted, count_o stays 8, no drop.
REQ-033 Empty queue, push id 0x55 at cycle T -> inj_valid_o=1 with inj_id_o=0x55 at T+1, not at T.
REQ-034 20 pushes and pops with random inj_ready_i -> ids emerge in order 1..20 across two pointer wraps, with fields unchanged while stalled.
REQ-035 count_o=5 then flush_i=1 together with req_valid_i=1 -> count_o=0 and inj_valid_o=0 next cycle, no drop; max_occ_o stays 5.
REQ-036 count_o=3, drive rst_i=0 between clock edges -> inj_valid_o=0 and count_o=0 immediately; after release, push id 7 -> inj_id_o=7 one cycle later.

Source files
------------

// File: rtl/synfull_inj_queue.sv
// Trace-request injection queue: circular FIFO between the SynFull DPI stage and the ProNoC injector.
// Latency: push to inj_valid_o is 1 cycle (FWFT, no bypass). Backpressure: req_ready_o = not full; a request arriving while full with no pop is dropped.
// Optional statistics (drop count, peak occupancy) are enabled by defining SYNFULL_INJQ_STATS_EN.
module synfull_inj_queue #(
  parameter int DEPTH  = 8,
  parameter int DST_W  = 8,
  parameter int ID_W   = 32,
  parameter int SIZE_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  input  logic [DST_W-1:0]         req_src_i,
  input  logic [DST_W-1:0]         req_dest_i,
  input  logic [ID_W-1:0]          req_id_i,
  input  logic [SIZE_W-1:0]        req_size_i,
  output logic                     req_ready_o,
  output logic                     inj_valid_o,
  output logic [DST_W-1:0]         inj_src_o,
  output logic [DST_W-1:0]         inj_dest_o,
  output logic [ID_W-1:0]          inj_id_o,
  output logic [SIZE_W-1:0]        inj_size_o,
  input  logic                     inj_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o,
  output logic [31:0]              drop_cnt_o,
  output logic [$clog2(DEPTH):0]   max_occ_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef struct packed {
    logic [DST_W-1:0]  src;
    logic [DST_W-1:0]  dest;
    logic [ID_W-1:0]   id;
    logic [SIZE_W-1:0] size;
  } req_t;

  req_t        r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  req_t w_req;
  req_t w_head;

  // Extra pointer MSB separates a full ring from an empty one.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_pop   = !w_empty && inj_ready_i;
  assign w_push  = req_valid_i && (!w_full || w_pop);

  assign w_req  = '{src: req_src_i, dest: req_dest_i, id: req_id_i, size: req_size_i};
  assign w_head = r_mem[r_rptr[AW-1:0]];

  assign req_ready_o = !w_full;
  assign inj_valid_o = !w_empty;
  assign inj_src_o   = w_head.src;
  assign inj_dest_o  = w_head.dest;
  assign inj_id_o    = w_head.id;
  assign inj_size_o  = w_head.size;
  assign count_o     = r_wptr - r_rptr;
  assign drop_o      = req_valid_i && w_full && !w_pop && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr[AW-1:0]] <= w_req;
  end

`ifdef SYNFULL_INJQ_STATS_EN
  logic [31:0] r_drop_cnt;
  logic [AW:0] r_max_occ;
  logic [AW:0] w_cnt_nxt;

  // Peak tracks the post-edge occupancy so it moves together with count_o.
  always_comb begin
    w_cnt_nxt = count_o;
    if (flush_i)             w_cnt_nxt = '0;
    else if (w_push && !w_pop) w_cnt_nxt = count_o + PTR_ONE;
    else if (w_pop && !w_push) w_cnt_nxt = count_o - PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_drop_cnt <= '0;
      r_max_occ  <= '0;
    end else begin
      if (drop_o && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_cnt_nxt > r_max_occ) r_max_occ <= w_cnt_nxt;
    end
  end

  assign drop_cnt_o = r_drop_cnt;
  assign max_occ_o  = r_max_occ;
`else
  assign drop_cnt_o = '0;
  assign max_occ_o  = '0;
`endif

endmodule

// File: tb/tb_synfull_inj_queue.sv
// Bench for synfull_inj_queue: queue-level reference model compared every cycle, plus directed literal checks.
module tb_synfull_inj_queue;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        req_valid_i;
  logic [7:0]  req_src_i;
  logic [7:0]  req_dest_i;
  logic [31:0] req_id_i;
  logic [15:0] req_size_i;
  logic        req_ready_o;
  logic        inj_valid_o;
  logic [7:0]  inj_src_o;
  logic [7:0]  inj_dest_o;
  logic [31:0] inj_id_o;
  logic [15:0] inj_size_o;
  logic        inj_ready_i;
  logic [3:0]  count_o;
  logic        drop_o;
  logic [31:0] drop_cnt_o;
  logic [3:0]  max_occ_o;

  synfull_inj_queue #(.DEPTH(DEPTH), .DST_W(8), .ID_W(32), .SIZE_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_src_i(req_src_i), .req_dest_i(req_dest_i),
    .req_id_i(req_id_i), .req_size_i(req_size_i), .req_ready_o(req_ready_o),
    .inj_valid_o(inj_valid_o), .inj_src_o(inj_src_o), .inj_dest_o(inj_dest_o),
    .inj_id_o(inj_id_o), .inj_size_o(inj_size_o), .inj_ready_i(inj_ready_i),
    .count_o(count_o), .drop_o(drop_o), .drop_cnt_o(drop_cnt_o), .max_occ_o(max_occ_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef SYNFULL_INJQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  dest;
    logic [31:0] id;
    logic [15:0] size;
  } ent_t;

  ent_t        mq[$];
  int          m_max;
  logic [31:0] m_dcnt;

  // Reference model: an ordered list of accepted requests.
  always @(posedge clk_i or negedge rst_i) begin
    bit full;
    bit pop;
    if (!rst_i) begin
      mq.delete();
      m_max  = 0;
      m_dcnt = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() > 0) && inj_ready_i;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (req_valid_i) begin
          if (!full || pop) mq.push_back('{src: req_src_i, dest: req_dest_i, id: req_id_i, size: req_size_i});
          else if (m_dcnt != 32'hFFFF_FFFF) m_dcnt++;
        end
      end
      if (mq.size() > m_max) m_max = mq.size();
    end
  end

  bit          chk_en = 1'b0;
  bit          seq_en = 1'b0;
  logic [31:0] exp_seq;

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("count", count_o, mq.size());
      chk("req_ready", req_ready_o, mq.size() < DEPTH);
      chk("inj_valid", inj_valid_o, mq.size() != 0);
      chk("drop", drop_o, rst_i && req_valid_i && !flush_i && (mq.size() == DEPTH) && !inj_ready_i);
      if (mq.size() > 0) begin
        chk("head_src", inj_src_o, mq[0].src);
        chk("head_dest", inj_dest_o, mq[0].dest);
        chk("head_id", inj_id_o, mq[0].id);
        chk("head_size", inj_size_o, mq[0].size);
      end
      chk("drop_cnt", drop_cnt_o, STATS ? m_dcnt : 32'd0);
      chk("max_occ", max_occ_o, STATS ? m_max : 0);
      if (seq_en && inj_valid_o && inj_ready_i) begin
        chk("seq_id", inj_id_o, exp_seq);
        exp_seq++;
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] id);
    req_valid_i = v;
    req_id_i    = id;
    req_src_i   = id[7:0] ^ 8'hA5;
    req_dest_i  = id[7:0] + 8'd3;
    req_size_i  = {id[14:0], 1'b0};
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  int next_id;

  initial begin
    rst_i = 1'b0;
    flush_i = 1'b0;
    inj_ready_i = 1'b0;
    drive(1'b0, 32'd0);
    #3;
    chk("rst_inj_valid", inj_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_drop", drop_o, 0);
    chk("rst_drop_cnt", drop_cnt_o, 0);
    chk("rst_max_occ", max_occ_o, 0);
    chk_en = 1'b1;
    #9 rst_i = 1'b1;
    step();

    // Latency: push into empty queue is visible one edge later, not before.
    drive(1'b1, 32'h55);
    #1 chk("lat_T_valid", inj_valid_o, 0);
    step();
    chk("lat_T1_valid", inj_valid_o, 1);
    chk("lat_T1_id", inj_id_o, 32'h55);
    drive(1'b0, 32'd0);
    inj_ready_i = 1'b1;
    step();
    inj_ready_i = 1'b0;

    // Fill, overflow drop, then push-with-pop at full.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i);
      step();
    end
    drive(1'b0, 32'd0);
    chk("full_ready", req_ready_o, 0);
    chk("full_count", count_o, 8);
    drive(1'b1, 32'd9);
    #1 chk("drop9_pulse", drop_o, 1);
    step();
    drive(1'b0, 32'd0);
    #1 chk("drop9_gone", drop_o, 0);
    chk("drop9_cnt", drop_cnt_o, STATS ? 32'd1 : 32'd0);
    chk("drop9_count", count_o, 8);
    chk("head_still1", inj_id_o, 1);
    drive(1'b1, 32'd10);
    inj_ready_i = 1'b1;
    #1 chk("pp_nodrop", drop_o, 0);
    chk("pp_pop_id", inj_id_o, 1);
    step();
    chk("pp_count", count_o, 8);
    chk("pp_head", inj_id_o, 2);
    drive(1'b0, 32'd0);
    repeat (8) step();
    chk("drained", count_o, 0);
    inj_ready_i = 1'b0;

    // Ordered stream across pointer wraps with random stalls.
    exp_seq = 32'd1;
    seq_en  = 1'b1;
    next_id = 1;
    for (int c = 0; c < 400 && exp_seq <= 20; c++) begin
      inj_ready_i = 1'($urandom_range(0, 1));
      if (next_id <= 20 && req_ready_o) begin
        drive(1'b1, next_id);
        next_id++;
      end else begin
        drive(1'b0, 32'd0);
      end
      step();
    end
    seq_en = 1'b0;
    drive(1'b0, 32'd0);
    inj_ready_i = 1'b1;
    chk("seq_done", exp_seq, 32'd21);
    step();
    inj_ready_i = 1'b0;

    // Fresh reset, occupy 5, flush with a concurrent push.
    #1 rst_i = 1'b0;
    #1 rst_i = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 100 + i);
      step();
    end
    drive(1'b0, 32'd0);
    chk("pre_flush_cnt", count_o, 5);
    flush_i = 1'b1;
    drive(1'b1, 32'd200);
    #1 chk("flush_nodrop", drop_o, 0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 32'd0);
    chk("flush_count", count_o, 0);
    chk("flush_valid", inj_valid_o, 0);
    chk("flush_max", max_occ_o, STATS ? 5 : 0);
    step();
    chk("flush_max_hold", max_occ_o, STATS ? 5 : 0);

    // Asynchronous reset between edges with 3 entries queued.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 30 + i);
      step();
    end
    drive(1'b0, 32'd0);
    chk("pre_rst_cnt", count_o, 3);
    #2 rst_i = 1'b0;
    #1 chk("arst_valid", inj_valid_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_max", max_occ_o, 0);
    #3 rst_i = 1'b1;
    drive(1'b1, 32'd7);
    #1 chk("rel_pre_valid", inj_valid_o, 0);
    step();
    chk("rel_valid", inj_valid_o, 1);
    chk("rel_id", inj_id_o, 7);
    chk("rel_count", count_o, 1);
    drive(1'b0, 32'd0);
    inj_ready_i = 1'b1;
    step();
    chk("final_count", count_o, 0);
    step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
